// File: rtl/golden_nonce_collector_pkg.sv
// rtl/golden_nonce_collector_pkg.sv - shared FSM encoding and pipe latency for the nonce collector
package golden_nonce_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } gn_state_e;

    // Cycles from a nonce being sampled by the hash pipe to its result at the pipe output.
    localparam int unsigned GN_LATENCY = 66;

endpackage

// File: rtl/gn_fifo.sv
// rtl/gn_fifo.sv - synchronous FIFO; a push into a full FIFO succeeds when a pop happens the same cycle
module gn_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/golden_nonce_collector.sv
// rtl/golden_nonce_collector.sv - nonce sequencer and golden-hit collector for the SHA-256 pipe (option: GN_HITCOUNT_EN)
module golden_nonce_collector
    import golden_nonce_collector_pkg::*;
#(
    parameter int unsigned LATENCY     = GN_LATENCY,
    parameter logic [31:0] MATCH_VALUE = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] nonce_start,
    input  logic [31:0] nonce_end,
    output logic [31:0] nonce_issue,
    output logic        issue_valid,
    input  logic [31:0] hash,
    output logic        gn_valid,
    output logic [31:0] gn_nonce,
    input  logic        gn_ready,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [15:0] hit_count
);

    gn_state_e          state_q, state_d;
    logic [31:0]        issue_cnt_q, issue_cnt_d;
    logic [31:0]        chk_cnt_q, chk_cnt_d;
    logic [31:0]        end_q, end_d;
    logic [LATENCY-1:0] vsr_q, vsr_d;
    logic               overflow_q, overflow_d;
    logic               start_acc;
    logic               last_issue;
    logic               hit;
    logic               pop;
    logic               push;
    logic               fifo_full;
    logic               fifo_empty;

    assign issue_valid = (state_q == ST_RUN);
    assign nonce_issue = issue_cnt_q;
    assign busy        = (state_q != ST_IDLE);
    assign overflow    = overflow_q;
    assign gn_valid    = !fifo_empty;

    assign start_acc  = (state_q == ST_IDLE) && start;
    assign last_issue = (issue_cnt_q == end_q) || stop;
    // The result leaving the top of the valid shift register belongs to the check counter's nonce.
    assign hit        = vsr_q[LATENCY-1] && (hash == MATCH_VALUE);
    assign pop        = !fifo_empty && gn_ready;
    assign push       = hit && (!fifo_full || pop);
    assign vsr_d      = {vsr_q[LATENCY-2:0], issue_valid};

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        chk_cnt_d   = chk_cnt_q;
        end_d       = end_q;
        overflow_d  = overflow_q;
        done        = 1'b0;

        if (vsr_q[LATENCY-1]) begin
            chk_cnt_d = chk_cnt_q + 32'd1;
        end
        if (hit && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    issue_cnt_d = nonce_start;
                    chk_cnt_d   = nonce_start;
                    end_d       = nonce_end;
                    overflow_d  = 1'b0;
                end
            end
            ST_RUN: begin
                // The counter freezes on the final nonce so nonce_issue holds it through DRAIN.
                if (last_issue) begin
                    state_d = ST_DRAIN;
                end else begin
                    issue_cnt_d = issue_cnt_q + 32'd1;
                end
            end
            ST_DRAIN: begin
                if (vsr_q[LATENCY-2:0] == '0) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            issue_cnt_q <= '0;
            chk_cnt_q   <= '0;
            end_q       <= '0;
            vsr_q       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            chk_cnt_q   <= chk_cnt_d;
            end_q       <= end_d;
            vsr_q       <= vsr_d;
            overflow_q  <= overflow_d;
        end
    end

    gn_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (chk_cnt_q),
        .pop       (pop),
        .head_data (gn_nonce),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef GN_HITCOUNT_EN
    logic [15:0] hit_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit_cnt_q <= '0;
        end else if (start_acc) begin
            hit_cnt_q <= '0;
        end else if (hit && (hit_cnt_q != 16'hFFFF)) begin
            hit_cnt_q <= hit_cnt_q + 16'd1;
        end
    end

    assign hit_count = hit_cnt_q;
`else
    assign hit_count = 16'h0000;
`endif

endmodule

// File: tb/tb_golden_nonce_collector.sv
// tb/tb_golden_nonce_collector.sv - randomized self-checking bench for golden_nonce_collector
module tb_golden_nonce_collector;

    localparam int LAT   = 4;
    localparam int DEPTH = 4;
`ifdef GN_HITCOUNT_EN
    localparam int HC_EN = 1;
`else
    localparam int HC_EN = 0;
`endif

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic [31:0] nonce_start;
    logic [31:0] nonce_end;
    logic [31:0] nonce_issue;
    logic        issue_valid;
    logic [31:0] hash;
    logic        gn_valid;
    logic [31:0] gn_nonce;
    logic        gn_ready;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] hit_count;

    golden_nonce_collector #(
        .LATENCY     (LAT),
        .MATCH_VALUE (32'h0000_0000),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .nonce_start (nonce_start),
        .nonce_end   (nonce_end),
        .nonce_issue (nonce_issue),
        .issue_valid (issue_valid),
        .hash        (hash),
        .gn_valid    (gn_valid),
        .gn_nonce    (gn_nonce),
        .gn_ready    (gn_ready),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .hit_count   (hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hash pipe model: fixed-latency delay of the issued nonce, masked and XORed with a key.
    logic [31:0] pipe [LAT];
    logic [31:0] hmask;
    logic [31:0] hkey;
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= nonce_issue;
    end
    assign hash = (pipe[LAT-1] & hmask) ^ hkey;

    int checks;
    int errors;
    int cyc;
    int done_cnt;
    int done_cyc;
    int last_issue_cyc;
    int first_gv_cyc;
    int ready_mode;
    logic [31:0] issued_q [$];
    int          issued_cyc [$];
    logic [31:0] popped_q [$];
    logic [31:0] exp_issue [$];
    logic [31:0] exp_gold [$];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (issue_valid) begin
            issued_q.push_back(nonce_issue);
            issued_cyc.push_back(cyc);
            last_issue_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (gn_valid && first_gv_cyc < 0) first_gv_cyc = cyc;
        case (ready_mode)
            0:       gn_ready = 1'b0;
            1:       gn_ready = 1'b1;
            2:       gn_ready = 1'($urandom_range(0, 1));
            default: gn_ready = done;
        endcase
        if (gn_valid && gn_ready) popped_q.push_back(gn_nonce);
    endtask

    task automatic build_expect(input logic [31:0] s, input logic [31:0] e, input int stop_after);
        logic [32:0] len;
        int n;
        logic [31:0] v;
        exp_issue.delete();
        exp_gold.delete();
        len = {1'b0, e - s} + 33'd1;
        n = (stop_after > 0 && 33'(stop_after) < len) ? stop_after : int'(len);
        for (int i = 0; i < n; i++) begin
            v = s + 32'(i);
            exp_issue.push_back(v);
            if ((v & hmask) == hkey) exp_gold.push_back(v);
        end
    endtask

    task automatic run(input logic [31:0] s, input logic [31:0] e, input int stop_after);
        int n;
        bit stopped;
        issued_q.delete();
        issued_cyc.delete();
        popped_q.delete();
        done_cnt = 0;
        first_gv_cyc = -1;
        n = 0;
        stopped = 1'b0;
        nonce_start = s;
        nonce_end = e;
        start = 1'b1;
        tick();
        start = 1'b0;
        nonce_start = $urandom;
        nonce_end = $urandom;
        while (done_cnt == 0 && n < 2000) begin
            if (stop_after > 0 && !stopped && issued_q.size() == stop_after) begin
                stop = 1'b1;
                stopped = 1'b1;
            end
            tick();
            stop = 1'b0;
            n++;
        end
    endtask

    task automatic drain();
        ready_mode = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!gn_valid) break;
        end
        ready_mode = 0;
    endtask

    task automatic cmp_issue(input string tag);
        checks++;
        if (issued_q.size() != exp_issue.size()) begin
            errors++;
            $display("FAIL %s issue_count: got %0d expected %0d", tag, issued_q.size(), exp_issue.size());
        end
        for (int i = 0; i < issued_q.size() && i < exp_issue.size(); i++) begin
            checks++;
            if (issued_q[i] !== exp_issue[i]) begin
                errors++;
                $display("FAIL %s issue[%0d]: got %h expected %h", tag, i, issued_q[i], exp_issue[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if ({issue_valid, busy, done, gn_valid, overflow} !== 5'b0 || nonce_issue !== 32'h0 ||
            gn_nonce !== 32'h0 || hit_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: iv=%b busy=%b done=%b gv=%b ovf=%b ni=%h gn=%h hc=%0d expected all 0",
                     issue_valid, busy, done, gn_valid, overflow, nonce_issue, gn_nonce, hit_count);
        end
    endtask

    task automatic test_basic_run();
        hmask = 32'hFFFF_FFFF;
        hkey = 32'h13;
        ready_mode = 0;
        build_expect(32'h10, 32'h17, 0);
        run(32'h10, 32'h17, 0);
        tick();
        cmp_issue("basic");
        checks++;
        if (done_cnt != 1 || done_cyc - last_issue_cyc != LAT) begin
            errors++;
            $display("FAIL basic_done: count %0d delay %0d expected 1 and %0d", done_cnt, done_cyc - last_issue_cyc, LAT);
        end
        checks++;
        if (issued_cyc.size() > 3 && first_gv_cyc != issued_cyc[3] + LAT + 1) begin
            errors++;
            $display("FAIL basic_gn_latency: gn_valid at %0d expected %0d", first_gv_cyc, issued_cyc[3] + LAT + 1);
        end
        drain();
        checks++;
        if (popped_q.size() != 1 || popped_q[0] !== 32'h13) begin
            errors++;
            $display("FAIL basic_gold: got %0d entries first %h expected 1 entry 00000013",
                     popped_q.size(), popped_q.size() > 0 ? popped_q[0] : 32'h0);
        end
    endtask

    task automatic test_wrap();
        hmask = 32'hFFFF_FFFF;
        hkey = 32'h0;
        build_expect(32'hFFFF_FFFE, 32'h0000_0001, 0);
        run(32'hFFFF_FFFE, 32'h0000_0001, 0);
        tick();
        cmp_issue("wrap");
        drain();
        checks++;
        if (popped_q.size() != 1 || popped_q[0] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_gold: got %0d entries expected 1 entry 00000000", popped_q.size());
        end
    endtask

    task automatic test_stop();
        hmask = ~32'h7;
        hkey = 32'h100;
        build_expect(32'h100, 32'h1FF, 3);
        run(32'h100, 32'h1FF, 3);
        tick();
        cmp_issue("stop");
        checks++;
        if (done_cnt != 1 || nonce_issue !== 32'h102) begin
            errors++;
            $display("FAIL stop_end: done %0d nonce_issue %h expected 1 and 00000102", done_cnt, nonce_issue);
        end
        drain();
        checks++;
        if (popped_q != exp_gold) begin
            errors++;
            $display("FAIL stop_gold: got %0d entries expected %0d", popped_q.size(), exp_gold.size());
        end
    endtask

    task automatic test_overflow();
        hmask = ~32'h7;
        hkey = 32'h200;
        ready_mode = 0;
        build_expect(32'h200, 32'h205, 0);
        run(32'h200, 32'h205, 0);
        tick();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: got %b expected 1", overflow);
        end
        checks++;
        if (hit_count !== 16'(HC_EN * exp_gold.size())) begin
            errors++;
            $display("FAIL ovf_hit_count: got %0d expected %0d", hit_count, HC_EN * exp_gold.size());
        end
        drain();
        checks++;
        if (popped_q.size() != DEPTH) begin
            errors++;
            $display("FAIL ovf_depth: got %0d entries expected %0d", popped_q.size(), DEPTH);
        end
        for (int i = 0; i < popped_q.size() && i < DEPTH; i++) begin
            checks++;
            if (popped_q[i] !== exp_gold[i]) begin
                errors++;
                $display("FAIL ovf_order[%0d]: got %h expected %h", i, popped_q[i], exp_gold[i]);
            end
        end
    endtask

    task automatic test_full_pop();
        hmask = ~32'h7;
        hkey = 32'h300;
        ready_mode = 3;
        build_expect(32'h300, 32'h304, 0);
        run(32'h300, 32'h304, 0);
        tick();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_ovf: got %b expected 0", overflow);
        end
        checks++;
        if (hit_count !== 16'(HC_EN * 5)) begin
            errors++;
            $display("FAIL fullpop_hit_count: got %0d expected %0d", hit_count, HC_EN * 5);
        end
        drain();
        checks++;
        if (popped_q != exp_gold) begin
            errors++;
            $display("FAIL fullpop_gold: got %0d entries expected %0d", popped_q.size(), exp_gold.size());
        end
    endtask

    task automatic test_random_runs();
        logic [31:0] s;
        logic [31:0] e;
        int len;
        int stp;
        for (int r = 0; r < 8; r++) begin
            s = (r % 2 == 1) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            len = $urandom_range(1, 24);
            e = s + 32'(len - 1);
            hmask = ($urandom_range(0, 1) == 1) ? ~32'h1 : 32'hFFFF_FFFF;
            hkey = (s + 32'($urandom_range(0, len - 1))) & hmask;
            stp = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len) : 0;
            ready_mode = 2;
            build_expect(s, e, stp);
            run(s, e, stp);
            tick();
            cmp_issue("random");
            checks++;
            if (done_cnt != 1 || overflow !== 1'b0) begin
                errors++;
                $display("FAIL random_done: run %0d done %0d ovf %b expected 1 and 0", r, done_cnt, overflow);
            end
            checks++;
            if (hit_count !== 16'(HC_EN * exp_gold.size())) begin
                errors++;
                $display("FAIL random_hit_count: run %0d got %0d expected %0d", r, hit_count, HC_EN * exp_gold.size());
            end
            drain();
            checks++;
            if (popped_q != exp_gold) begin
                errors++;
                $display("FAIL random_gold: run %0d got %0d entries expected %0d", r, popped_q.size(), exp_gold.size());
            end
        end
    endtask

    task automatic test_reset_mid_run();
        hmask = ~32'hF;
        hkey = 32'h500;
        ready_mode = 0;
        issued_q.delete();
        done_cnt = 0;
        nonce_start = 32'h500;
        nonce_end = 32'h5FF;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        nonce_start = 32'hDEAD_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (issued_q.size() != 4 || issued_q[issued_q.size()-1] !== 32'h503 || busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_start_ignored: got %0d issues last %h busy %b expected 4, 00000503, 1",
                     issued_q.size(), issued_q[issued_q.size()-1], busy);
        end
        repeat (6) tick();
        reset_n = 1'b0;
        tick();
        checks++;
        if ({issue_valid, busy, done, gn_valid, overflow} !== 5'b0 || nonce_issue !== 32'h0 || hit_count !== 16'h0) begin
            errors++;
            $display("FAIL midrun_reset: iv=%b busy=%b done=%b gv=%b ovf=%b ni=%h hc=%0d expected all 0",
                     issue_valid, busy, done, gn_valid, overflow, nonce_issue, hit_count);
        end
        reset_n = 1'b1;
        repeat (8) tick();
        checks++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrun_no_done: done %0d busy %b expected 0 and 0", done_cnt, busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        done_cnt = 0;
        done_cyc = 0;
        last_issue_cyc = 0;
        first_gv_cyc = -1;
        ready_mode = 0;
        reset_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        nonce_start = 32'h0;
        nonce_end = 32'h0;
        gn_ready = 1'b0;
        hmask = 32'hFFFF_FFFF;
        hkey = 32'hFFFF_FFFF;
        @(negedge clk);
        test_reset();
        test_basic_run();
        test_wrap();
        test_stop();
        test_overflow();
        test_full_pop();
        test_random_runs();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
